// File: rtl/cnn_pkg.sv
// Shared CNN definitions.
// Purpose : geometry constants for the pooled feature maps, the signed 8-bit
//           sample type shared with the memory banks, and the state
//           encoding of the fully connected output stage.
// Ports   : none (package).
package cnn_pkg;

    localparam int IMG_W         = 28;            // full-resolution row pitch in a bank
    localparam int POOL_DIM      = 14;            // pooled map is POOL_DIM x POOL_DIM
    localparam int FEAT_PER_CH   = 196;           // pooled features per channel
    localparam int PAIRS_PER_CH  = 98;            // two features fetched per cycle
    localparam int PAIRS_PER_ROW = POOL_DIM / 2;  // 7 pairs per pooled row

    typedef logic signed [7:0] data8_t;

    typedef enum logic [2:0] {
        FC_IDLE,
        FC_READ,
        FC_DRAIN1,
        FC_DRAIN2,
        FC_EMIT,
        FC_FIN
    } fc_state_t;

endpackage

// File: rtl/fc_classifier_if.sv
// Bus bundle of the fully connected classifier.
// Purpose : groups start, the broadcast bank read port, the weight/bias ROM
//           ports and the result outputs.
// Ports   : master = classifier side (drives addresses and results),
//           slave  = environment side (banks, ROMs, result consumer).
interface fc_classifier_if #(
    parameter int CH    = 8,
    parameter int ACC_W = 26
);
    import cnn_pkg::*;

    logic                    start;
    logic                    load;
    logic [9:0]              addr1;
    logic [9:0]              addr2;
    logic [CH*8-1:0]         data1_bus;
    logic [CH*8-1:0]         data2_bus;
    logic [13:0]             w_addr1;
    logic [13:0]             w_addr2;
    data8_t                  w_data1;
    data8_t                  w_data2;
    logic [3:0]              b_addr;
    data8_t                  b_data;
    logic                    out_valid;
    logic [3:0]              out_class;
    logic signed [ACC_W-1:0] out_logit;
    logic                    done;
    logic [3:0]              pred_class;
    logic                    busy;

    modport master (
        input  start, data1_bus, data2_bus, w_data1, w_data2, b_data,
        output load, addr1, addr2, w_addr1, w_addr2, b_addr,
               out_valid, out_class, out_logit, done, pred_class, busy
    );

    modport slave (
        output start, data1_bus, data2_bus, w_data1, w_data2, b_data,
        input  load, addr1, addr2, w_addr1, w_addr2, b_addr,
               out_valid, out_class, out_logit, done, pred_class, busy
    );

endinterface

// File: rtl/fc_addr_gen.sv
// Address generator for the fully connected stage.
// Purpose : holds the class (k), channel (c) and pair counters and derives
//           the bank, weight and bias addresses of the pair being read.
// Ports   : clk, rst              - clock, async active-high reset
//           clear                 - restart at k=0, c=0, p=0
//           advance               - step to the next pair (wraps into c)
//           next_class            - k+1, c=0, p=0
//           addr1/addr2           - bank addresses of the current pair
//           w_addr1/w_addr2       - weight ROM addresses of the current pair
//           b_addr                - bias address (= k)
//           chan                  - channel of the current pair
//           last_pair/last_class  - final pair of the class / final class
module fc_addr_gen
    import cnn_pkg::*;
#(
    parameter int CH      = 8,
    parameter int N_CLASS = 10,
    parameter int CH_W    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    input  logic            next_class,
    output logic [9:0]      addr1,
    output logic [9:0]      addr2,
    output logic [13:0]     w_addr1,
    output logic [13:0]     w_addr2,
    output logic [3:0]      b_addr,
    output logic [CH_W-1:0] chan,
    output logic            last_pair,
    output logic            last_class
);

    // The pair index p is kept as pooled row r and column-pair q so that no
    // divide by 7 is needed.
    logic [3:0]      k_q, k_d;
    logic [CH_W-1:0] c_q, c_d;
    logic [3:0]      r_q, r_d;
    logic [2:0]      q_q, q_d;
    logic [6:0]      p_d;
    logic [9:0]      addr1_q, addr1_d, addr2_q, addr2_d;
    logic [13:0]     w_addr1_q, w_addr1_d, w_addr2_q, w_addr2_d;

    always_comb begin
        k_d = k_q;
        c_d = c_q;
        r_d = r_q;
        q_d = q_q;
        if (clear) begin
            k_d = '0;
            c_d = '0;
            r_d = '0;
            q_d = '0;
        end else if (next_class) begin
            k_d = k_q + 4'd1;
            c_d = '0;
            r_d = '0;
            q_d = '0;
        end else if (advance) begin
            if (q_q == 3'(PAIRS_PER_ROW - 1)) begin
                q_d = '0;
                if (r_q == 4'(POOL_DIM - 1)) begin
                    r_d = '0;
                    c_d = c_q + CH_W'(1);
                end else begin
                    r_d = r_q + 4'd1;
                end
            end else begin
                q_d = q_q + 3'd1;
            end
        end

        p_d = 7'(r_d) * 7'(PAIRS_PER_ROW) + 7'(q_d);

        // Pooled pixels live at even columns of even rows: pooled (r, 2q)
        // is full-res (2r, 4q), so the stride is two image rows per r.
        addr1_d   = 10'(r_d) * 10'(2 * IMG_W) + 10'(q_d) * 10'd4;
        addr2_d   = addr1_d + 10'd2;
        w_addr1_d = 14'(k_d) * 14'(CH * FEAT_PER_CH)
                  + 14'(c_d) * 14'(FEAT_PER_CH)
                  + 14'(p_d) * 14'd2;
        w_addr2_d = w_addr1_d + 14'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= '0;
            c_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            w_addr1_q <= '0;
            w_addr2_q <= '0;
        end else begin
            k_q       <= k_d;
            c_q       <= c_d;
            r_q       <= r_d;
            q_q       <= q_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            w_addr1_q <= w_addr1_d;
            w_addr2_q <= w_addr2_d;
        end
    end

    assign addr1      = addr1_q;
    assign addr2      = addr2_q;
    assign w_addr1    = w_addr1_q;
    assign w_addr2    = w_addr2_q;
    assign b_addr     = k_q;
    assign chan       = c_q;
    assign last_pair  = (q_q == 3'(PAIRS_PER_ROW - 1)) && (r_q == 4'(POOL_DIM - 1))
                     && (c_q == CH_W'(CH - 1));
    assign last_class = (k_q == 4'(N_CLASS - 1));

endmodule

// File: rtl/fc_classifier.sv
// Fully connected output stage.
// Purpose : after start, streams every channel's 14x14 pooled map two
//           pixels per cycle, multiply-accumulates against signed weights,
//           adds a per-class bias, emits one logit per class and finally
//           the argmax class.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset
//           bus  - fc_classifier_if.master: start, bank/weight/bias read
//                  ports, out_valid/out_class/out_logit, done, pred_class,
//                  busy
module fc_classifier
    import cnn_pkg::*;
#(
    parameter int CH      = 8,
    parameter int N_CLASS = 10,
    parameter int ACC_W   = 26
) (
    input logic             clk,
    input logic             rst,
    fc_classifier_if.master bus
);

    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    fc_state_t               state_q, state_d;
    logic                    load_q, load_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    out_valid_q, out_valid_d;
    logic [3:0]              out_class_q, out_class_d;
    logic signed [ACC_W-1:0] out_logit_q, out_logit_d;
    logic [3:0]              pred_q, pred_d;
    logic signed [ACC_W-1:0] max_q, max_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] logit;

    // Two-stage pipeline: stage 1 is the cycle the bank/ROM data is on the
    // bus, stage 2 holds the registered product sum.
    logic                    valid1_q, valid1_d;
    logic [CH_W-1:0]         ch1_q, ch1_d;
    logic                    valid2_q, valid2_d;
    logic signed [16:0]      prod_q, prod_d;
    logic signed [15:0]      mul1, mul2;

    logic                    clear, advance, next_class;
    logic [CH_W-1:0]         chan;
    logic [3:0]              k_cur;
    logic                    last_pair, last_class;

    data8_t data1_ch [CH];
    data8_t data2_ch [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_unpack
            assign data1_ch[gi] = bus.data1_bus[8*gi +: 8];
            assign data2_ch[gi] = bus.data2_bus[8*gi +: 8];
        end
    endgenerate

    fc_addr_gen #(
        .CH      (CH),
        .N_CLASS (N_CLASS),
        .CH_W    (CH_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .advance    (advance),
        .next_class (next_class),
        .addr1      (bus.addr1),
        .addr2      (bus.addr2),
        .w_addr1    (bus.w_addr1),
        .w_addr2    (bus.w_addr2),
        .b_addr     (k_cur),
        .chan       (chan),
        .last_pair  (last_pair),
        .last_class (last_class)
    );

    always_comb begin
        state_d     = state_q;
        clear       = 1'b0;
        advance     = 1'b0;
        next_class  = 1'b0;
        out_valid_d = 1'b0;
        out_class_d = out_class_q;
        out_logit_d = out_logit_q;
        pred_d      = pred_q;
        max_d       = max_q;
        logit       = '0;

        valid1_d = (state_q == FC_READ);
        ch1_d    = chan;
        valid2_d = valid1_q;
        mul1     = 16'(data1_ch[ch1_q]) * 16'(bus.w_data1);
        mul2     = 16'(data2_ch[ch1_q]) * 16'(bus.w_data2);
        prod_d   = 17'(mul1) + 17'(mul2);

        acc_d = valid2_q ? (acc_q + ACC_W'(prod_q)) : acc_q;

        case (state_q)
            FC_IDLE: begin
                if (bus.start) begin
                    state_d = FC_READ;
                    clear   = 1'b1;
                    acc_d   = '0;
                    max_d   = '0;
                end
            end
            FC_READ: begin
                if (last_pair) begin
                    state_d = FC_DRAIN1;
                end else begin
                    advance = 1'b1;
                end
            end
            FC_DRAIN1: state_d = FC_DRAIN2;
            FC_DRAIN2: begin
                // The final accumulate lands on this edge, so the logit is
                // formed from acc_d to have it registered during EMIT.
                state_d     = FC_EMIT;
                logit       = acc_d + ACC_W'(bus.b_data);
                out_valid_d = 1'b1;
                out_class_d = k_cur;
                out_logit_d = logit;
                // Strict compare: ties keep the lower class index.
                if ((k_cur == 4'd0) || (logit > max_q)) begin
                    max_d  = logit;
                    pred_d = k_cur;
                end
            end
            FC_EMIT: begin
                acc_d = '0;
                if (last_class) begin
                    state_d = FC_FIN;
                end else begin
                    state_d    = FC_READ;
                    next_class = 1'b1;
                end
            end
            FC_FIN:  state_d = FC_IDLE;
            default: state_d = FC_IDLE;
        endcase

        load_d = (state_d == FC_READ);
        busy_d = (state_d != FC_IDLE);
        done_d = (state_d == FC_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FC_IDLE;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_logit_q <= '0;
            pred_q      <= '0;
            max_q       <= '0;
            acc_q       <= '0;
            valid1_q    <= 1'b0;
            ch1_q       <= '0;
            valid2_q    <= 1'b0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_logit_q <= out_logit_d;
            pred_q      <= pred_d;
            max_q       <= max_d;
            acc_q       <= acc_d;
            valid1_q    <= valid1_d;
            ch1_q       <= ch1_d;
            valid2_q    <= valid2_d;
            prod_q      <= prod_d;
        end
    end

    assign bus.load       = load_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_class  = out_class_q;
    assign bus.out_logit  = out_logit_q;
    assign bus.pred_class = pred_q;
    assign bus.b_addr     = k_cur;

endmodule

// File: tb/tb_fc_classifier.sv
// Testbench for fc_classifier: bank, weight and bias memories with one-cycle
// registered reads, a pooled-map dot-product reference, and timing checks
// against the cycle of the first READ (t=0).
module tb_fc_classifier;
    import cnn_pkg::*;

    localparam int CH       = 8;
    localparam int N_CLASS  = 10;
    localparam int ACC_W    = 26;
    localparam int PERIOD   = CH * PAIRS_PER_CH + 3;
    localparam int RUN_LEN  = PERIOD * N_CLASS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_classifier_if #(.CH(CH), .ACC_W(ACC_W)) bus ();

    fc_classifier #(.CH(CH), .N_CLASS(N_CLASS), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data8_t bank_mem [CH][1024];
    data8_t w_mem    [16384];
    data8_t bias_mem [16];

    longint exp_logit [N_CLASS];
    int     exp_pred;

    int checks   = 0;
    int failures = 0;

    // Memory models: registered reads, banks only on load.
    always @(posedge clk) begin
        if (bus.load) begin
            for (int c = 0; c < CH; c++) begin
                bus.data1_bus[8*c +: 8] <= bank_mem[c][bus.addr1];
                bus.data2_bus[8*c +: 8] <= bank_mem[c][bus.addr2];
            end
        end
        bus.w_data1 <= w_mem[bus.w_addr1];
        bus.w_data2 <= w_mem[bus.w_addr2];
        bus.b_data  <= bias_mem[bus.b_addr];
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: logit_k = bias_k + sum over channels and pooled (y,x) of
    // pooled pixel * weight, with pooled (y,x) at full-res (2y,2x).
    function automatic void build_expected();
        longint s;
        int     best;
        for (int k = 0; k < N_CLASS; k++) begin
            s = longint'(bias_mem[k]);
            for (int c = 0; c < CH; c++)
                for (int y = 0; y < POOL_DIM; y++)
                    for (int x = 0; x < POOL_DIM; x++)
                        s += longint'(bank_mem[c][2*y*IMG_W + 2*x])
                           * longint'(w_mem[k*CH*FEAT_PER_CH + c*FEAT_PER_CH + y*POOL_DIM + x]);
            exp_logit[k] = s;
        end
        best = 0;
        for (int k = 1; k < N_CLASS; k++)
            if (exp_logit[k] > exp_logit[best]) best = k;
        exp_pred = best;
    endfunction

    // mode 0: all ones; 1: pixel = addr[7:0], only class 3 weighted, bias = k;
    // 2: extreme magnitudes; 3: random.
    task automatic fill(input int mode);
        logic [9:0] av;
        for (int c = 0; c < CH; c++) begin
            for (int a = 0; a < 1024; a++) begin
                av = 10'(a);
                case (mode)
                    0:       bank_mem[c][a] = data8_t'(1);
                    1:       bank_mem[c][a] = av[7:0];
                    2:       bank_mem[c][a] = data8_t'(127);
                    default: bank_mem[c][a] = data8_t'($urandom);
                endcase
            end
        end
        for (int i = 0; i < 16384; i++) begin
            case (mode)
                0:       w_mem[i] = data8_t'(1);
                1:       w_mem[i] = (i / (CH*FEAT_PER_CH) == 3) ? data8_t'(1) : data8_t'(0);
                2:       w_mem[i] = data8_t'(-128);
                default: w_mem[i] = data8_t'($urandom);
            endcase
        end
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       bias_mem[k] = data8_t'(0);
                1:       bias_mem[k] = data8_t'(k);
                2:       bias_mem[k] = data8_t'(-128);
                default: bias_mem[k] = data8_t'($urandom);
            endcase
        end
        build_expected();
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_val({pfx, "_load"},       bus.load,       0);
        check_val({pfx, "_busy"},       bus.busy,       0);
        check_val({pfx, "_done"},       bus.done,       0);
        check_val({pfx, "_out_valid"},  bus.out_valid,  0);
        check_val({pfx, "_addr1"},      bus.addr1,      0);
        check_val({pfx, "_addr2"},      bus.addr2,      0);
        check_val({pfx, "_w_addr1"},    bus.w_addr1,    0);
        check_val({pfx, "_w_addr2"},    bus.w_addr2,    0);
        check_val({pfx, "_b_addr"},     bus.b_addr,     0);
        check_val({pfx, "_out_class"},  bus.out_class,  0);
        check_val({pfx, "_pred_class"}, bus.pred_class, 0);
        check_val({pfx, "_out_logit"},  bus.out_logit,  0);
    endtask

    // One full run; extra_start pulses start mid-READ and again during FIN.
    task automatic run_once(input string name, input bit extra_start);
        int nv;
        nv = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; t <= RUN_LEN + 1; t++) begin
            if (t > 0) @(negedge clk);
            if (extra_start) begin
                if (t == 100 || t == RUN_LEN)          bus.start = 1'b1;
                else if (t == 101 || t == RUN_LEN + 1) bus.start = 1'b0;
            end
            if (t == 0) begin
                check_val("load_t0",    bus.load,    1);
                check_val("busy_t0",    bus.busy,    1);
                check_val("addr1_t0",   bus.addr1,   0);
                check_val("w_addr1_t0", bus.w_addr1, 0);
            end
            if (t == 6) begin
                check_val("addr1_p6", bus.addr1, 24);
                check_val("addr2_p6", bus.addr2, 26);
            end
            if (t == 7) begin
                check_val("addr1_p7", bus.addr1, 56);
                check_val("addr2_p7", bus.addr2, 58);
            end
            if (t == PERIOD + PAIRS_PER_CH) begin
                check_val("w_addr1_k1c1", bus.w_addr1, 1764);
                check_val("w_addr2_k1c1", bus.w_addr2, 1765);
                check_val("b_addr_k1",    bus.b_addr,  1);
            end
            if (t == CH * PAIRS_PER_CH)
                check_val("load_drain", bus.load, 0);
            if (bus.out_valid) begin
                if (nv < N_CLASS) begin
                    check_val("logit_time",  t,             PERIOD*nv + PERIOD - 1);
                    check_val("logit_class", bus.out_class, nv);
                    check_val("logit_value", bus.out_logit, exp_logit[nv]);
                end else begin
                    check_val("extra_out_valid", t, -1);
                end
                $display("%s: class %0d logit %0d at t=%0d", name, bus.out_class, bus.out_logit, t);
                nv++;
            end
            if (bus.done || t == RUN_LEN)
                check_val("done_time", bus.done ? t : -1, RUN_LEN);
            if (t == RUN_LEN) begin
                check_val("busy_fin",    bus.busy,       1);
                check_val("logit_count", nv,             N_CLASS);
                check_val("pred_class",  bus.pred_class, exp_pred);
            end
            if (t == RUN_LEN + 1)
                check_val("busy_idle", bus.busy, 0);
        end
        bus.start = 1'b0;
        $display("%s: done, pred_class %0d", name, bus.pred_class);
    endtask

    initial begin
        int quiet;
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        fill(0); run_once("ones",    1'b0);
        fill(1); run_once("pattern", 1'b0);
        fill(2); run_once("extreme", 1'b0);
        fill(3); run_once("random",  1'b1);

        // Abort mid-run with a two-cycle reset.
        fill(3);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        quiet = 0;
        repeat (2 * PERIOD) begin
            @(negedge clk);
            if (bus.out_valid || bus.done || bus.busy || bus.load) quiet++;
        end
        check_val("abort_quiet", quiet, 0);
        $display("abort: quiet cycles checked");

        fill(3); run_once("after_abort", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
